// File: rtl/camera_controller_if.sv
// Camera controller bus: frame strobe, raw buttons and follow target in,
// published camera position and status out.
//   new_frame_in  one-cycle frame-start pulse
//   btn_in        raw pan buttons [3] -x, [2] +x, [1] -y, [0] +y
//   follow_en_in  follow-mode enable
//   target_*_in   follow target in world space (signed)
//   camera_*_out  published camera position (signed)
//   moving_out    last publish changed the camera position
//   update_out    one-cycle pulse when a new position is published
interface camera_controller_if #(
  parameter int WORLD_BITS = 18
) ();
  logic                         new_frame_in;
  logic [3:0]                   btn_in;
  logic                         follow_en_in;
  logic signed [WORLD_BITS-1:0] target_x_in;
  logic signed [WORLD_BITS-1:0] target_y_in;
  logic signed [WORLD_BITS-1:0] camera_x_out;
  logic signed [WORLD_BITS-1:0] camera_y_out;
  logic                         moving_out;
  logic                         update_out;

  modport master (
    output new_frame_in, btn_in, follow_en_in, target_x_in, target_y_in,
    input  camera_x_out, camera_y_out, moving_out, update_out
  );

  modport slave (
    input  new_frame_in, btn_in, follow_en_in, target_x_in, target_y_in,
    output camera_x_out, camera_y_out, moving_out, update_out
  );
endinterface

// File: rtl/camera_controller.sv
// Camera position stage on the render clock. Debounces the pan buttons,
// applies accelerating manual panning or deadzone follow of a target once
// per frame, clamps to world bounds and publishes the result.
//   clk_in  render clock
//   rst_in  asynchronous active-low reset
//   bus     camera_controller_if slave (see interface header)
//
// state   | meaning
// IDLE    | waiting for new_frame_in
// SAMPLE  | latch target, follow enable, buttons; update speed
// STEP    | compute unclamped next position
// CLAMP   | saturate to bounds, register outputs, raise update
// PUBLISH | update_out high for this cycle
module camera_controller #(
  parameter int WORLD_BITS      = 18,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int MAX_SPEED       = 8,
  parameter int ACCEL_FRAMES    = 4,
  parameter int FOLLOW_DEADZONE = 200,
  parameter int INIT_X          = 640,
  parameter int INIT_Y          = 360,
  parameter int MIN_X           = -4096,
  parameter int MAX_X           = 65535,
  parameter int MIN_Y           = -4096,
  parameter int MAX_Y           = 8191
) (
  input logic               clk_in,
  input logic               rst_in,
  camera_controller_if.slave bus
);
  localparam int W  = WORLD_BITS;
  localparam int WW = WORLD_BITS + 2;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int AW = $clog2(ACCEL_FRAMES + 1);

  localparam logic signed [WW-1:0] MIN_X_W = WW'(MIN_X);
  localparam logic signed [WW-1:0] MAX_X_W = WW'(MAX_X);
  localparam logic signed [WW-1:0] MIN_Y_W = WW'(MIN_Y);
  localparam logic signed [WW-1:0] MAX_Y_W = WW'(MAX_Y);
  localparam logic signed [WW-1:0] DZ_W    = WW'(FOLLOW_DEADZONE);

  typedef enum logic [2:0] {IDLE, SAMPLE, STEP, CLAMP, PUBLISH} state_t;

  state_t state_q, state_nxt;

  logic [3:0]    sync_q1, sync_q2, btn_db;
  logic [CW-1:0] db_cnt [4];

  logic [3:0]          btn_q;
  logic                follow_q;
  logic signed [W-1:0] tgt_x_q, tgt_y_q;
  logic [SW-1:0]       speed_q;
  logic [AW-1:0]       acc_q;
  logic signed [WW-1:0] next_x_q, next_y_q;
  logic signed [W-1:0] camera_x_q, camera_y_q;
  logic                moving_q, update_q;

  logic                 manual_now, manual_q;
  logic signed [WW-1:0] cam_x_w, cam_y_w, tgt_x_w, tgt_y_w, spd_w;
  logic signed [WW-1:0] step_x, step_y, clamp_x, clamp_y;

  // 2-FF synchroniser followed by a per-bit stability counter; the accepted
  // state flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      btn_db  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_q1 <= bus.btn_in;
      sync_q2 <= sync_q1;
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] != btn_db[i]) begin
          if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db[i] <= ~btn_db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Opposing buttons on an axis cancel, so XOR detects a live direction.
  assign manual_now = (btn_db[2] ^ btn_db[3]) | (btn_db[0] ^ btn_db[1]);
  assign manual_q   = (btn_q[2] ^ btn_q[3]) | (btn_q[0] ^ btn_q[1]);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.new_frame_in) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = STEP;
      STEP:    state_nxt = CLAMP;
      CLAMP:   state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cam_x_w = WW'(camera_x_q);
  assign cam_y_w = WW'(camera_y_q);
  assign tgt_x_w = WW'(tgt_x_q);
  assign tgt_y_w = WW'(tgt_y_q);
  assign spd_w   = signed'(WW'(speed_q));

  function automatic logic signed [WW-1:0] follow_step(
    input logic signed [WW-1:0] cam,
    input logic signed [WW-1:0] tgt
  );
    logic signed [WW-1:0] d, mag, step;
    d   = tgt - cam;
    mag = (d < 0) ? -d : d;
    if (mag <= DZ_W) return cam;
    step = (mag - DZ_W) >>> 2;
    if (step == '0) step = WW'(1);
    return (d < 0) ? cam - step : cam + step;
  endfunction

  function automatic logic signed [WW-1:0] sat(
    input logic signed [WW-1:0] v,
    input logic signed [WW-1:0] lo,
    input logic signed [WW-1:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Manual panning takes priority; follow only runs with no live direction.
  always_comb begin
    step_x = cam_x_w;
    step_y = cam_y_w;
    if (manual_q) begin
      if (btn_q[2] & ~btn_q[3])      step_x = cam_x_w + spd_w;
      else if (btn_q[3] & ~btn_q[2]) step_x = cam_x_w - spd_w;
      if (btn_q[0] & ~btn_q[1])      step_y = cam_y_w + spd_w;
      else if (btn_q[1] & ~btn_q[0]) step_y = cam_y_w - spd_w;
    end else if (follow_q) begin
      step_x = follow_step(cam_x_w, tgt_x_w);
      step_y = follow_step(cam_y_w, tgt_y_w);
    end
  end

  assign clamp_x = sat(next_x_q, MIN_X_W, MAX_X_W);
  assign clamp_y = sat(next_y_q, MIN_Y_W, MAX_Y_W);

  // Outputs are loaded on the CLAMP->PUBLISH edge so the new position and
  // update_out appear together in the PUBLISH cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      btn_q      <= '0;
      follow_q   <= 1'b0;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      speed_q    <= '0;
      acc_q      <= '0;
      next_x_q   <= '0;
      next_y_q   <= '0;
      camera_x_q <= W'(INIT_X);
      camera_y_q <= W'(INIT_Y);
      moving_q   <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        SAMPLE: begin
          btn_q    <= btn_db;
          follow_q <= bus.follow_en_in;
          tgt_x_q  <= bus.target_x_in;
          tgt_y_q  <= bus.target_y_in;
          if (manual_now) begin
            if (speed_q == '0) begin
              speed_q <= SW'(1);
              acc_q   <= '0;
            end else if (acc_q == AW'(ACCEL_FRAMES - 1)) begin
              acc_q <= '0;
              if (speed_q != SW'(MAX_SPEED)) speed_q <= speed_q + SW'(1);
            end else begin
              acc_q <= acc_q + AW'(1);
            end
          end else begin
            speed_q <= '0;
            acc_q   <= '0;
          end
        end
        STEP: begin
          next_x_q <= step_x;
          next_y_q <= step_y;
        end
        CLAMP: begin
          camera_x_q <= W'(clamp_x);
          camera_y_q <= W'(clamp_y);
          moving_q   <= (clamp_x != cam_x_w) || (clamp_y != cam_y_w);
          update_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.camera_x_out = camera_x_q;
  assign bus.camera_y_out = camera_y_q;
  assign bus.moving_out   = moving_q;
  assign bus.update_out   = update_q;
endmodule

// File: doc/camera_controller.md
Name: camera_controller

Overview:
- Produces the world-space camera position (camera_x_out, camera_y_out) that feeds pixel_to_world and render on the render clock domain.
- Replaces the inline button-stepping logic with a dedicated stage that has:
  - per-button debounce
  - per-frame accelerating manual panning
  - an optional follow mode that tracks a target point (the car) with a deadzone
  - clamping to world bounds
- Updates once per new frame, so the camera is stable while a frame is drawn.

Parameters:
- WORLD_BITS, 18, width of signed world coordinates.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles before a button state is accepted (>=2).
- MAX_SPEED, 8, maximum manual pan step in world units per frame.
- ACCEL_FRAMES, 4, held frames per +1 speed increment.
- FOLLOW_DEADZONE, 200, follow-mode distance tolerated without motion, per axis.
- INIT_X, 640, camera x after reset.
- INIT_Y, 360, camera y after reset.
- MIN_X, -4096, lowest allowed camera x.
- MAX_X, 65535, highest allowed camera x.
- MIN_Y, -4096, lowest allowed camera y.
- MAX_Y, 8191, highest allowed camera y.

Ports:
- clk_in  input  1  render clock.
- rst_in  input  1  asynchronous, active-low reset.
- new_frame_in  input  1  one-cycle pulse at frame start.
- btn_in  input  4  raw buttons: [3] pan -x, [2] pan +x, [1] pan -y, [0] pan +y.
- follow_en_in  input  1  enables follow mode when no pan button is active.
- target_x_in  input  WORLD_BITS signed  follow target x.
- target_y_in  input  WORLD_BITS signed  follow target y.
- camera_x_out  output  WORLD_BITS signed  camera x.
- camera_y_out  output  WORLD_BITS signed  camera y.
- moving_out  output  1  high while the last update moved the camera.
- update_out  output  1  one-cycle pulse when new camera values are published.

Behaviour:

Reset:
- All outputs reset: camera_x_out=INIT_X, camera_y_out=INIT_Y, moving_out=0, update_out=0.
- Internal state reset: state IDLE, speed=0, accel count=0, debounced buttons=0, sync flops=0.
- Reset mid-frame aborts the update; no partial values are published.

Debounce:
- Each btn_in bit passes through a 2-FF synchroniser, then a per-bit counter.
- The debounced state flips only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any glitch back to the current state zeroes the counter.

Direction:
- dir_x = (+1 if btn[2]) + (-1 if btn[3]); dir_y = (+1 if btn[0]) + (-1 if btn[1]).
- Opposing buttons cancel.
- Manual is active if dir_x != 0 or dir_y != 0.

FSM (IDLE, SAMPLE, STEP, CLAMP, PUBLISH):
- IDLE: on new_frame_in -> SAMPLE.
  - new_frame_in in any other state is ignored (no queueing).
- SAMPLE: latch target_x_in, target_y_in, follow_en_in and the debounced buttons.
  - Manual active:
    - accel count +1; when it reaches ACCEL_FRAMES it wraps to 0 and speed +1, saturating at MAX_SPEED.
    - The first active frame sets speed=1 with accel count 0.
  - Manual inactive: speed=0, accel count=0.
  - -> STEP.
- STEP: compute next_x/next_y in WORLD_BITS+2 signed arithmetic.
  - Manual: next = cam + dir*speed on each axis; the axis with dir=0 is unchanged.
  - Follow, per axis: d = target - cam.
    - If |d| <= FOLLOW_DEADZONE: no move on that axis.
    - Otherwise move toward the target by max(1, (|d|-FOLLOW_DEADZONE)>>2).
  - Neither manual nor follow: next = cam.
  - -> CLAMP.
- CLAMP: saturate next_x to [MIN_X, MAX_X] and next_y to [MIN_Y, MAX_Y]. -> PUBLISH.
- PUBLISH: register the camera outputs.
  - moving_out = (new != old) on either axis.
  - update_out=1 for exactly this cycle.
  - -> IDLE.

Latency:
- new_frame_in in cycle N -> outputs and update_out change in cycle N+4.
- Outputs hold constant between publishes.

Boundaries:
- Clamp engaged while pushing into a bound: the camera stays at the bound, moving_out=0, speed keeps saturating.
- Wide intermediates make the computation overflow-free for any in-range target.

Test Plan (DEBOUNCE_CYCLES=4, ACCEL_FRAMES=2 unless noted):
- Reset release, no buttons, 3 frames -> camera=(640,360) throughout; update_out pulses 4 cycles after each new_frame_in; moving_out=0.
- Hold btn[2] stable, 5 frames -> x = 641, 642, 644, 646, 649 (speed 1,1,2,2,3); y=360; moving_out=1.
- btn[2] glitch high for 3 cycles only -> no debounce flip; camera unchanged after the next frame.
- btn[2]+btn[3] held together -> x unchanged, speed=0, moving_out=0.
- Follow mode, target=(1240,360), no buttons:
  - frame 1: d=600 -> x=740 (step (600-200)>>2=100).
  - frame 2: d=500 -> x=815.
  - Target at x=800 from cam 640: d=160 -> no move.
- MIN_X=0, camera x=2, hold btn[3] at speed>=2 -> x clamps to 0 and stays; moving_out=0 on later frames.
- Assert rst_in low between new_frame_in and PUBLISH -> outputs return to (640,360); no update_out pulse.
